dot_product_engine: RTL and testbench
=====================================

// Module: dot_product_engine
// PURPOSE
//   Parametrised N-lane dot-product unit: computes sum(data[i]*weight[i]) with a
//   sequential MAC, one lane per cycle. Supports signed/unsigned mode,
//   accumulate-across-runs with saturation, and byte-serial result readout
//   with valid/ready. Sits between the pin-level load/readout logic and the
//   host-side shift protocol.
// PARAMETERS
//   N_LANES  4   number of element pairs per dot product (>=2)
//   DATA_W   8   element width, bits
//   ACC_W    20  accumulator/result width, bits (>= 2*DATA_W)
//   (localparam OUT_BYTES = ceil(ACC_W/8))
// PORTS
//   clk          in   1       clock, all logic on posedge
//   rst_n        in   1       synchronous active-low reset
//   in_valid     in   1       element write strobe
//   in_ready     out  1       element can be accepted (high only in IDLE)
//   in_sel       in   1       0 = data vector, 1 = weight vector
//   in_data      in   DATA_W  element value
//   start        in   1       begin computation (honoured only in IDLE)
//   signed_mode  in   1       sampled at start: 1 = two's-complement operands
//   acc_clear    in   1       sampled at start: 1 = accumulate from 0, 0 = add to previous result
//   busy         out  1       high in COMPUTE or OUTPUT
//   out_valid    out  1       out_data holds a result byte
//   out_ready    in   1       consumer accepts byte when out_valid & out_ready
//   out_data     out  8       result byte, LSB byte first
//   out_last     out  1       high with final byte (index OUT_BYTES-1)
//   ovf          out  1       sticky saturation flag
// BEHAVIOUR
//   - Reset: all lane regs, accumulator, mode regs = 0; state IDLE; in_ready=1,
//     busy=0, out_valid=0, out_data=0, out_last=0, ovf=0.
//   - Load: in IDLE, in_valid&in_ready shifts selected vector: lane0<=in_data,
//     lane[i]<=lane[i-1]. The last element written lands in lane 0. Other
//     vector untouched. in_valid outside IDLE is ignored.
//   - FSM IDLE -> COMPUTE on start. COMPUTE -> OUTPUT after N_LANES cycles.
//     OUTPUT -> IDLE on the handshake of the last byte. start outside IDLE is ignored.
//   - start and in_valid in the same IDLE cycle: the load is performed first;
//     compute uses the updated vectors.
//   - At start: latch signed_mode and acc_clear. The working sum is the
//     previous result (acc_clear=0) or 0 (acc_clear=1). ovf is cleared only
//     when acc_clear=1.
//   - COMPUTE: one product per cycle, lane 0 first. Product = 2*DATA_W bits,
//     sign- or zero-extended per mode. Accumulation uses ACC_W+1 internal bits.
//     After every add the sum is saturated to the ACC_W range:
//     unsigned [0, 2^ACC_W-1]; signed [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//     Any saturation sets ovf.
//   - Latency: start at cycle t -> out_valid=1 at cycle t+N_LANES+1.
//   - OUTPUT: result is extended to OUT_BYTES*8 bits (sign-extended in signed
//     mode, else zero) and sent byte 0 first. out_data/out_last hold stable
//     while out_valid & ~out_ready. Each handshake advances one byte.
//     out_valid drops the cycle after the last handshake.
//   - The result register persists through IDLE for later accumulation.
//     Lane registers are not cleared by start.
//   - rst_n low in any state aborts immediately to reset values. A partial
//     sum is discarded.
// TESTING
//   (N_LANES=4, DATA_W=8, ACC_W=20, OUT_BYTES=3)
//   1 unsigned: data 4,3,2,1 and weights 8,7,6,5 written in that order
//     (lane0 = last written: data 1, weight 5); start, clear=1
//     -> 70: bytes 0x46,0x00,0x00; out_last on byte 2; out_valid at t+5.
//   2 accumulate: rerun test 1 with clear=0 -> 140: bytes 0x8C,0x00,0x00; ovf=0.
//   3 signed: data all 0xFF, weights all 0x02; signed=1, clear=1 -> -8:
//     bytes 0xF8,0xFF,0xFF.
//   4 saturation: all lanes 0xFF/0xFF unsigned (260100 per run), 5 runs with
//     clear=0 after the first -> result 0xFFFFF, ovf=1. A following run with
//     clear=1 -> ovf=0.
//   5 backpressure: out_ready=0 for 10 cycles in OUTPUT -> out_data stable,
//     out_valid=1, in_ready=0, start ignored. Release -> 3 bytes, then IDLE.
//   6 reset mid-COMPUTE (rst_n=0 at t+2) -> next cycle busy=0, out_valid=0,
//     ovf=0. A rerun of test 1 -> 70.

Source files
------------

// File: rtl/dot_product_engine.sv
// N-lane dot-product unit: shift-loaded operand lanes, one MAC per cycle with
// saturating accumulate across runs, and byte-serial valid/ready result readout.

module dpe_lane #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load_d,
    input  logic              i_load_w,
    input  logic [DATA_W-1:0] i_d,
    input  logic [DATA_W-1:0] i_w,
    output logic [DATA_W-1:0] o_d,
    output logic [DATA_W-1:0] o_w
);
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_w;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d <= '0;
            r_w <= '0;
        end else begin
            if (i_load_d) r_d <= i_d;
            if (i_load_w) r_w <= i_w;
        end
    end

    assign o_d = r_d;
    assign o_w = r_w;
endmodule

module dot_product_engine #(
    parameter int N_LANES = 4,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              start,
    input  logic              signed_mode,
    input  logic              acc_clear,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              ovf
);
    localparam int OUT_BYTES = (ACC_W + 7) / 8;
    localparam int OUT_W     = OUT_BYTES * 8;
    localparam int IDX_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int BYTE_W    = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_LANES - 1);
    localparam logic signed [ACC_W:0] SMAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SMIN = {2'b11, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [BYTE_W-1:0]  r_byte;
    logic [ACC_W-1:0]   r_acc;
    logic               r_signed;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_out_valid;
    logic [7:0]         r_out_data;
    logic               r_out_last;

    // Lane 0 takes the new element; every other lane takes its lower neighbour.
    logic [N_LANES-1:0][DATA_W-1:0] w_lane_d;
    logic [N_LANES-1:0][DATA_W-1:0] w_lane_w;
    logic                           w_load;
    logic                           w_load_d;
    logic                           w_load_w;

    assign w_load   = in_valid && (r_state == S_IDLE);
    assign w_load_d = w_load && !in_sel;
    assign w_load_w = w_load && in_sel;

    genvar g;
    generate
        for (g = 0; g < N_LANES; g++) begin : g_lane
            logic [DATA_W-1:0] w_src_d;
            logic [DATA_W-1:0] w_src_w;
            if (g == 0) begin : g_head
                assign w_src_d = in_data;
                assign w_src_w = in_data;
            end else begin : g_tail
                assign w_src_d = w_lane_d[g-1];
                assign w_src_w = w_lane_w[g-1];
            end
            dpe_lane #(.DATA_W(DATA_W)) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_load_d (w_load_d),
                .i_load_w (w_load_w),
                .i_d      (w_src_d),
                .i_w      (w_src_w),
                .o_d      (w_lane_d[g]),
                .o_w      (w_lane_w[g])
            );
        end
    endgenerate

    logic [DATA_W-1:0]          w_cur_d;
    logic [DATA_W-1:0]          w_cur_w;
    logic signed [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0]        w_prod_u;
    logic signed [ACC_W:0]      w_prod_se;
    logic signed [ACC_W:0]      w_acc_se;
    logic signed [ACC_W:0]      w_sum_s;
    logic [ACC_W:0]             w_sum_u;
    logic [ACC_W-1:0]           w_sat;
    logic                       w_sat_hit;

    assign w_cur_d   = w_lane_d[r_idx];
    assign w_cur_w   = w_lane_w[r_idx];
    assign w_prod_s  = $signed(w_cur_d) * $signed(w_cur_w);
    assign w_prod_u  = w_cur_d * w_cur_w;
    assign w_prod_se = {{(ACC_W+1-2*DATA_W){w_prod_s[2*DATA_W-1]}}, w_prod_s};
    assign w_acc_se  = $signed({r_acc[ACC_W-1], r_acc});
    assign w_sum_s   = w_acc_se + w_prod_se;
    assign w_sum_u   = {1'b0, r_acc} + (ACC_W+1)'(w_prod_u);

    // One spare bit of headroom means a single add can only overshoot, never wrap.
    always_comb begin
        w_sat     = w_sum_u[ACC_W-1:0];
        w_sat_hit = 1'b0;
        if (r_signed) begin
            if (w_sum_s > SMAX) begin
                w_sat     = {1'b0, {(ACC_W-1){1'b1}}};
                w_sat_hit = 1'b1;
            end else if (w_sum_s < SMIN) begin
                w_sat     = {1'b1, {(ACC_W-1){1'b0}}};
                w_sat_hit = 1'b1;
            end else begin
                w_sat = w_sum_s[ACC_W-1:0];
            end
        end else if (w_sum_u[ACC_W]) begin
            w_sat     = '1;
            w_sat_hit = 1'b1;
        end
    end

    function automatic logic [OUT_W-1:0] f_extend(input logic [ACC_W-1:0] acc,
                                                  input logic sg);
        logic [OUT_W-1:0] v;
        v = '0;
        v[ACC_W-1:0] = acc;
        for (int b = ACC_W; b < OUT_W; b++) v[b] = sg & acc[ACC_W-1];
        return v;
    endfunction

    logic [OUT_W-1:0] w_first_ext;
    logic [OUT_W-1:0] w_res_ext;
    logic [7:0]       w_next_byte;
    logic             w_next_last;

    assign w_first_ext = f_extend(w_sat, r_signed);
    assign w_res_ext   = f_extend(r_acc, r_signed);
    assign w_next_byte = 8'(w_res_ext >> (8 * (int'(r_byte) + 1)));
    assign w_next_last = (int'(r_byte) + 2) == OUT_BYTES;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_byte      <= '0;
            r_acc       <= '0;
            r_signed    <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_COMPUTE;
                        r_signed   <= signed_mode;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        if (acc_clear) begin
                            r_acc <= '0;
                            r_ovf <= 1'b0;
                        end
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_sat;
                    if (w_sat_hit) r_ovf <= 1'b1;
                    if (r_idx == LAST_IDX) begin
                        // First byte comes straight from the final sum so it is ready on entry.
                        r_state     <= S_OUTPUT;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_first_ext[7:0];
                        r_out_last  <= (OUT_BYTES == 1);
                        r_byte      <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_byte     <= r_byte + 1'b1;
                            r_out_data <= w_next_byte;
                            r_out_last <= w_next_last;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine: a plain-arithmetic model predicts every
// result byte, and literal expectations pin both the model and the DUT.

module tb_dot_product_engine;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sel = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          start = 1'b0;
    logic          signed_mode = 1'b0;
    logic          acc_clear = 1'b0;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_data;
    logic          out_last;
    logic          ovf;

    dot_product_engine #(.N_LANES(N), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sel      (in_sel),
        .in_data     (in_data),
        .start       (start),
        .signed_mode (signed_mode),
        .acc_clear   (acc_clear),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: lane contents, result register, sticky flag, pending bytes.
    logic [7:0] m_d [N];
    logic [7:0] m_w [N];
    longint     m_acc = 0;
    logic       m_ovf = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] got [3];
    int         gk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_d[i] = '0;
            m_w[i] = '0;
        end
        m_acc = 0;
        m_ovf = 1'b0;
        exp_q.delete();
    endtask

    task automatic m_start(input bit sg, input bit clr);
        longint s, p, e;
        if (clr) begin
            m_acc = 0;
            m_ovf = 1'b0;
        end
        s = (sg && m_acc >= 524288) ? m_acc - 1048576 : m_acc;
        for (int i = 0; i < N; i++) begin
            if (sg) p = longint'($signed(m_d[i])) * longint'($signed(m_w[i]));
            else    p = longint'(m_d[i]) * longint'(m_w[i]);
            s = s + p;
            if (sg && s > 524287)        begin s = 524287;  m_ovf = 1'b1; end
            else if (sg && s < -524288)  begin s = -524288; m_ovf = 1'b1; end
            else if (!sg && s > 1048575) begin s = 1048575; m_ovf = 1'b1; end
        end
        m_acc = s & 64'hFFFFF;
        e = s & 64'hFFFFFF;
        for (int b = 0; b < 3; b++) exp_q.push_back(8'(e >> (8 * b)));
    endtask

    task automatic load(input bit sel, input logic [7:0] v);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = v;
        for (int i = N - 1; i > 0; i--) begin
            if (sel) m_w[i] = m_w[i-1];
            else     m_d[i] = m_d[i-1];
        end
        if (sel) m_w[0] = v;
        else     m_d[0] = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_vecs(input logic [31:0] dv, input logic [31:0] wv);
        for (int i = 3; i >= 0; i--) load(1'b0, dv[8*i +: 8]);
        for (int i = 3; i >= 0; i--) load(1'b1, wv[8*i +: 8]);
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("drain_to_idle", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run(input bit sg, input bit clr, input bit chk_lat);
        int n;
        signed_mode = sg;
        acc_clear   = clr;
        start       = 1'b1;
        m_start(sg, clr);
        tick();
        start = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (chk_lat) chk("latency", n, N + 1);
        else         chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
        wait_done();
    endtask

    task automatic chk_bytes(input string nm, input logic [23:0] v);
        chk({nm, "_b0"}, got[0], v[7:0]);
        chk({nm, "_b1"}, got[1], v[15:8]);
        chk({nm, "_b2"}, got[2], v[23:16]);
    endtask

    // Compare process: every valid byte against the model, captured on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                chk("out_data", out_data, exp_q[0]);
                chk("out_last", {31'd0, out_last}, {31'd0, exp_q.size() == 1});
                chk("ovf_model", {31'd0, ovf}, {31'd0, m_ovf});
                if (out_ready) begin
                    if (gk < 3) got[gk] = out_data;
                    gk = out_last ? 0 : gk + 1;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        m_reset();
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: unsigned 70
        load_vecs(32'h04030201, 32'h08070605);
        run(1'b0, 1'b1, 1'b1);
        chk("t1_model", 32'(m_acc), 32'd70);
        chk_bytes("t1", 24'h000046);

        // 2: accumulate to 140
        run(1'b0, 1'b0, 1'b1);
        chk("t2_model", 32'(m_acc), 32'd140);
        chk_bytes("t2", 24'h00008C);
        chk("t2_ovf", {31'd0, ovf}, 32'd0);

        // 3: signed -8
        load_vecs(32'hFFFFFFFF, 32'h02020202);
        run(1'b1, 1'b1, 1'b1);
        chk_bytes("t3", 24'hFFFFF8);

        // 5: backpressure; start and loads during OUTPUT must be ignored
        load_vecs(32'h04030201, 32'h08070605);
        out_ready   = 1'b0;
        signed_mode = 1'b0;
        acc_clear   = 1'b1;
        start       = 1'b1;
        m_start(1'b0, 1'b1);
        tick();
        start = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("t5_latency", n, N + 1);
        for (int c = 0; c < 10; c++) begin
            start       = 1'b1;
            signed_mode = 1'b1;
            in_valid    = 1'b1;
            in_sel      = 1'b0;
            in_data     = 8'h55;
            tick();
            chk("t5_hold_data", {24'd0, out_data}, 32'h46);
            chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
        end
        start       = 1'b0;
        in_valid    = 1'b0;
        signed_mode = 1'b0;
        out_ready   = 1'b1;
        wait_done();
        chk_bytes("t5", 24'h000046);
        chk("t5_q_empty", exp_q.size(), 32'd0);
        run(1'b0, 1'b1, 1'b0);
        chk_bytes("t5_lanes_kept", 24'h000046);

        // 4: saturation then clear
        load_vecs(32'hFFFFFFFF, 32'hFFFFFFFF);
        run(1'b0, 1'b1, 1'b0);
        chk("t4_model_run1", 32'(m_acc), 32'd260100);
        for (int r = 0; r < 4; r++) run(1'b0, 1'b0, 1'b0);
        chk("t4_model_sat", 32'(m_acc), 32'hFFFFF);
        chk_bytes("t4_sat", 24'h0FFFFF);
        chk("t4_ovf_set", {31'd0, ovf}, 32'd1);
        run(1'b0, 1'b1, 1'b0);
        chk_bytes("t4_clear", 24'h03F804);
        chk("t4_ovf_clear", {31'd0, ovf}, 32'd0);

        // 6: reset mid-COMPUTE with ovf set
        for (int r = 0; r < 4; r++) run(1'b0, 1'b0, 1'b0);
        chk("t6_ovf_pre", {31'd0, ovf}, 32'd1);
        acc_clear = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        m_reset();
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_ovf", {31'd0, ovf}, 32'd0);
        chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();
        load_vecs(32'h04030201, 32'h08070605);
        run(1'b0, 1'b1, 1'b1);
        chk_bytes("t6_rerun", 24'h000046);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
